// File: rtl/tdc_fine_encoder.sv
// TDC fine encoder: thermometer popcount plus coarse counter into a FWFT timestamp FIFO.
// Flags thermometer bubbles and sticky FIFO overflow.
module tdc_fine_encoder #(
    parameter int TAPS       = 4,
    parameter int COARSE_W   = 16,
    parameter int FIFO_DEPTH = 4,
    localparam int FINE_W    = $clog2(TAPS + 1),
    localparam int TS_W      = COARSE_W + FINE_W
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [TAPS-1:0]     THERM,
    input  logic                THERM_VALID,
    input  logic                CLEAR,
    output logic [TS_W-1:0]     TS_DATA,
    output logic                TS_VALID,
    input  logic                TS_READY,
    output logic                BUBBLE_ERR,
    output logic                OVERFLOW
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [COARSE_W-1:0] coarse;
    logic                s1_valid;
    logic [TAPS-1:0]     s1_therm;
    logic [COARSE_W-1:0] s1_coarse;
    logic [FINE_W-1:0]   fine;
    logic                legal;
    logic [TAPS:0]       therm_inc;

    logic [TS_W-1:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [AW:0]         count;
    logic [TS_W-1:0]     last;
    logic                full;
    logic                pop;
    logic                push;
    logic                drop;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            coarse <= '0;
        end else if (CLEAR) begin
            coarse <= '0;
        end else begin
            coarse <= coarse + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s1_valid  <= 1'b0;
            s1_therm  <= '0;
            s1_coarse <= '0;
        end else begin
            s1_valid <= THERM_VALID & ~CLEAR;
            if (THERM_VALID) begin
                s1_therm  <= THERM;
                s1_coarse <= coarse;
            end
        end
    end

    // A legal thermometer plus one is a power of two with no overlap.
    always_comb begin
        fine = '0;
        for (int i = 0; i < TAPS; i++) begin
            fine = fine + FINE_W'(s1_therm[i]);
        end
        therm_inc = {1'b0, s1_therm} + 1'b1;
        legal     = (therm_inc[TAPS-1:0] & s1_therm) == '0;
    end

    assign full = count == (AW + 1)'(FIFO_DEPTH);
    assign pop  = (count != '0) & TS_READY;
    assign push = s1_valid & (~full | pop);
    assign drop = s1_valid & full & ~pop;

    always_ff @(posedge CLK) begin
        if (push && !CLEAR) begin
            mem[wr_ptr] <= {s1_coarse, fine};
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            last       <= '0;
            OVERFLOW   <= 1'b0;
            BUBBLE_ERR <= 1'b0;
        end else if (CLEAR) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            OVERFLOW   <= 1'b0;
            BUBBLE_ERR <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                last   <= mem[rd_ptr];
            end
            count      <= count + (AW + 1)'(push) - (AW + 1)'(pop);
            OVERFLOW   <= OVERFLOW | drop;
            BUBBLE_ERR <= s1_valid & ~legal;
        end
    end

    // When empty the output keeps showing the last word handed out.
    assign TS_VALID = count != '0;
    assign TS_DATA  = TS_VALID ? mem[rd_ptr] : last;

endmodule

// File: tb/tb_tdc_fine_encoder.sv
// Scoreboard bench for tdc_fine_encoder: directed hits, bubbles, overflow,
// simultaneous push/pop, counter wrap, clear and asynchronous reset.
module tb_tdc_fine_encoder;

    logic        clk;
    logic        rst_n;
    logic [3:0]  therm;
    logic        therm_valid;
    logic        clear;
    logic [18:0] ts_data;
    logic        ts_valid;
    logic        ts_ready;
    logic        bubble_err;
    logic        overflow;

    logic [3:0]  therm4;
    logic        therm_valid4;
    logic        clear4;
    logic [6:0]  ts_data4;
    logic        ts_valid4;
    logic        ts_ready4;
    logic        bubble_err4;
    logic        overflow4;

    logic [15:0] exp_cnt;
    logic [3:0]  exp_cnt4;
    logic [18:0] q[$];
    logic [6:0]  q4[$];

    int checks   = 0;
    int failures = 0;

    tdc_fine_encoder #(.TAPS(4), .COARSE_W(16), .FIFO_DEPTH(4)) dut (
        .CLK(clk), .RST_N(rst_n), .THERM(therm), .THERM_VALID(therm_valid),
        .CLEAR(clear), .TS_DATA(ts_data), .TS_VALID(ts_valid),
        .TS_READY(ts_ready), .BUBBLE_ERR(bubble_err), .OVERFLOW(overflow)
    );

    tdc_fine_encoder #(.TAPS(4), .COARSE_W(4), .FIFO_DEPTH(4)) dut4 (
        .CLK(clk), .RST_N(rst_n), .THERM(therm4), .THERM_VALID(therm_valid4),
        .CLEAR(clear4), .TS_DATA(ts_data4), .TS_VALID(ts_valid4),
        .TS_READY(ts_ready4), .BUBBLE_ERR(bubble_err4), .OVERFLOW(overflow4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference coarse counters: value seen before the next rising edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) exp_cnt <= '0;
        else if (clear) exp_cnt <= '0;
        else exp_cnt <= exp_cnt + 1'b1;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) exp_cnt4 <= '0;
        else if (clear4) exp_cnt4 <= '0;
        else exp_cnt4 <= exp_cnt4 + 1'b1;
    end

    always @(negedge clk) begin
        if (rst_n && ts_valid && ts_ready) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_ts got=%h want=none", ts_data);
            end else begin
                logic [18:0] e;
                e = q.pop_front();
                if (ts_data !== e) begin
                    failures++;
                    $display("FAIL ts_word got=%h want=%h", ts_data, e);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && ts_valid4 && ts_ready4) begin
            checks++;
            if (q4.size() == 0) begin
                failures++;
                $display("FAIL unexpected_ts4 got=%h want=none", ts_data4);
            end else begin
                logic [6:0] e;
                e = q4.pop_front();
                if (ts_data4 !== e) begin
                    failures++;
                    $display("FAIL ts4_word got=%h want=%h", ts_data4, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic hit(input logic [3:0] t, input logic [2:0] f,
                       input bit keep);
        therm       = t;
        therm_valid = 1'b1;
        if (keep) q.push_back({exp_cnt, f});
        tick();
        therm_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        therm        = '0;
        therm_valid  = 1'b0;
        clear        = 1'b0;
        ts_ready     = 1'b0;
        therm4       = '0;
        therm_valid4 = 1'b0;
        clear4       = 1'b0;
        ts_ready4    = 1'b1;
        #1;
        chk("rst_valid", 32'(ts_valid), 0);
        chk("rst_data", 32'(ts_data), 0);
        chk("rst_bubble", 32'(bubble_err), 0);
        chk("rst_ovf", 32'(overflow), 0);
        tick();
        tick();
        rst_n = 1'b1;

        // Basic hit at counter 0x0010, two-cycle latency
        for (int i = 0; i < 40 && exp_cnt != 16'h0010; i++) tick();
        chk("align_cnt", 32'(exp_cnt), 32'h10);
        ts_ready = 1'b1;
        hit(4'b0111, 3'd3, 1);
        chk("lat1_valid", 32'(ts_valid), 0);
        tick();
        chk("lat2_valid", 32'(ts_valid), 1);
        chk("t1_data", 32'(ts_data), 32'({16'h0010, 3'd3}));
        tick();
        chk("t1_popped", 32'(ts_valid), 0);

        // Bubble and edge-case codes
        hit(4'b0101, 3'd2, 1);
        tick();
        chk("bubble_on", 32'(bubble_err), 1);
        tick();
        chk("bubble_off", 32'(bubble_err), 0);
        hit(4'b1111, 3'd4, 1);
        tick();
        chk("no_bubble_1111", 32'(bubble_err), 0);
        tick();
        hit(4'b0000, 3'd0, 1);
        chk("zero_lat1", 32'(ts_valid), 0);
        tick();
        chk("no_bubble_0000", 32'(bubble_err), 0);
        chk("zero_valid", 32'(ts_valid), 1);
        tick();

        // Fill and overflow
        ts_ready = 1'b0;
        hit(4'b0001, 3'd1, 1);
        hit(4'b0011, 3'd2, 1);
        hit(4'b0111, 3'd3, 1);
        hit(4'b1111, 3'd4, 1);
        hit(4'b0000, 3'd0, 0);
        chk("ovf_not_yet", 32'(overflow), 0);
        tick();
        chk("ovf_set", 32'(overflow), 1);
        chk("full_valid", 32'(ts_valid), 1);
        ts_ready = 1'b1;
        repeat (6) tick();
        chk("drain_all", 32'(q.size()), 0);
        chk("drain_empty", 32'(ts_valid), 0);
        chk("ovf_sticky", 32'(overflow), 1);
        ts_ready = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("ovf_cleared", 32'(overflow), 0);

        // Full FIFO with simultaneous push and pop
        hit(4'b0001, 3'd1, 1);
        hit(4'b0011, 3'd2, 1);
        hit(4'b0111, 3'd3, 1);
        hit(4'b1111, 3'd4, 1);
        hit(4'b0111, 3'd3, 1);
        ts_ready = 1'b1;
        tick();
        ts_ready = 1'b0;
        chk("pushpop_no_ovf", 32'(overflow), 0);
        tick();
        chk("pushpop_valid", 32'(ts_valid), 1);
        ts_ready = 1'b1;
        repeat (6) tick();
        chk("pushpop_drain", 32'(q.size()), 0);
        chk("pushpop_empty", 32'(ts_valid), 0);

        // Coarse wrap on the 4-bit instance
        for (int i = 0; i < 40 && exp_cnt4 != 4'hF; i++) tick();
        therm4       = 4'b0001;
        therm_valid4 = 1'b1;
        q4.push_back({4'hF, 3'd1});
        tick();
        therm4 = 4'b0011;
        q4.push_back({4'h0, 3'd2});
        tick();
        therm_valid4 = 1'b0;
        repeat (4) tick();
        chk("wrap_drain", 32'(q4.size()), 0);

        // Clear with buffered and in-flight hits
        ts_ready = 1'b0;
        hit(4'b0001, 3'd1, 0);
        hit(4'b0011, 3'd2, 0);
        hit(4'b0111, 3'd3, 0);
        clear       = 1'b1;
        therm       = 4'b0101;
        therm_valid = 1'b1;
        tick();
        clear       = 1'b0;
        therm_valid = 1'b0;
        chk("clr_valid", 32'(ts_valid), 0);
        chk("clr_bubble", 32'(bubble_err), 0);
        tick();
        chk("clr_no_late", 32'(ts_valid), 0);
        ts_ready = 1'b1;
        q.push_back({16'd1, 3'd1});
        hit(4'b0001, 3'd1, 0);
        repeat (5) tick();
        chk("clr_drain", 32'(q.size()), 0);

        // Asynchronous reset between edges
        ts_ready = 1'b0;
        hit(4'b0001, 3'd1, 0);
        hit(4'b0011, 3'd2, 0);
        hit(4'b0111, 3'd3, 0);
        hit(4'b1111, 3'd4, 0);
        hit(4'b0101, 3'd2, 0);
        tick();
        chk("pre_rst_ovf", 32'(overflow), 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(ts_valid), 0);
        chk("arst_data", 32'(ts_data), 0);
        chk("arst_ovf", 32'(overflow), 0);
        chk("arst_bubble", 32'(bubble_err), 0);
        #1;
        rst_n = 1'b1;
        tick();
        ts_ready = 1'b1;
        q.push_back({16'd1, 3'd4});
        hit(4'b1111, 3'd4, 0);
        repeat (5) tick();
        chk("rst_drain", 32'(q.size()), 0);
        chk("rst_empty", 32'(ts_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
